// File: rtl/servile_mem_sched.sv
// Round-robin Wishbone-classic scheduler sharing one memory port between
// ibus, dbus and a DMA/debug master, with a bus timeout and a gap cycle after each transfer.
module servile_mem_sched #(
  parameter int timeout = 255,
  parameter int tw      = $clog2(timeout + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_stb,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_stb,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  input  logic [31:0] i_wb_dma_adr,
  input  logic [31:0] i_wb_dma_dat,
  input  logic [3:0]  i_wb_dma_sel,
  input  logic        i_wb_dma_we,
  input  logic        i_wb_dma_stb,
  output logic [31:0] o_wb_dma_rdt,
  output logic        o_wb_dma_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_err,
  output logic [1:0]  o_owner
);

  localparam int cw = (tw < 1) ? 1 : tw;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  owner_reg, owner_next;
  logic [1:0]  rr_reg, rr_next;

  logic [3:0]  req_stb;
  logic [1:0]  cand [3];
  logic [2:0]  hit;
  logic        win_valid;
  logic [1:0]  win;

  logic        own_stb;
  logic [31:0] own_adr;
  logic [31:0] own_dat;
  logic [3:0]  own_sel;
  logic        own_we;

  logic        busy;
  logic        done_ack;
  logic        tmo_hit;
  logic        finish;
  logic        kill;
  logic        ack_any;
  logic [2:0]  ack_vec;
  logic [31:0] rdt_vec [3];

  // Index 3 (no owner) reads as an idle requester.
  assign req_stb = {1'b0, i_wb_dma_stb, i_wb_dbus_stb, i_wb_ibus_stb};

  // cand[gi] is the requester gi places after the round-robin pointer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum       = {1'b0, rr_reg} + 3'(gi);
    assign cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign hit[gi]   = req_stb[cand[gi]];
  end

  assign win_valid = |hit;
  assign win       = hit[0] ? cand[0] : (hit[1] ? cand[1] : cand[2]);

  always_comb begin
    own_stb = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    case (owner_reg)
      2'd0: begin
        own_stb = i_wb_ibus_stb;
        own_adr = i_wb_ibus_adr;
        own_sel = 4'hf;
      end
      2'd1: begin
        own_stb = i_wb_dbus_stb;
        own_adr = i_wb_dbus_adr;
        own_dat = i_wb_dbus_dat;
        own_sel = i_wb_dbus_sel;
        own_we  = i_wb_dbus_we;
      end
      2'd2: begin
        own_stb = i_wb_dma_stb;
        own_adr = i_wb_dma_adr;
        own_dat = i_wb_dma_dat;
        own_sel = i_wb_dma_sel;
        own_we  = i_wb_dma_we;
      end
      default: ;
    endcase
  end

  assign busy     = (state_reg == BUSY);
  assign done_ack = busy & own_stb & i_wb_mem_ack;
  // A dropped strobe aborts the transfer; a real ack always beats the timeout.
  assign finish   = busy & (~own_stb | i_wb_mem_ack | tmo_hit);

  if (timeout > 0) begin : g_tmo
    logic [cw-1:0] cnt_reg;
    always_ff @(posedge i_clk) begin
      if (i_rst || !busy) cnt_reg <= '0;
      else if (!i_wb_mem_ack) cnt_reg <= cnt_reg + cw'(1);
    end
    assign tmo_hit = busy & own_stb & ~i_wb_mem_ack & (cnt_reg == cw'(timeout));
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      owner_reg <= 2'd3;
      rr_reg    <= 2'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next = BUSY;
          owner_next = win;
        end
      end
      BUSY: begin
        if (finish) begin
          state_next = GAP;
          owner_next = 2'd3;
          rr_next    = (owner_reg == 2'd2) ? 2'd0 : owner_reg + 2'd1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    kill         = ~i_rst & tmo_hit;
    ack_any      = ~i_rst & (done_ack | tmo_hit);
    o_wb_mem_stb = ~i_rst & busy & own_stb & ~tmo_hit;
    o_wb_mem_adr = own_adr;
    o_wb_mem_dat = own_dat;
    o_wb_mem_sel = own_sel;
    o_wb_mem_we  = own_we;
    o_err        = kill;
    o_owner      = i_rst ? 2'd3 : owner_reg;
  end

  // Read data is broadcast; only a timed-out owner sees zeros.
  for (genvar gi = 0; gi < 3; gi++) begin : g_resp
    assign ack_vec[gi] = ack_any & (owner_reg == 2'(gi));
    assign rdt_vec[gi] = (kill && owner_reg == 2'(gi)) ? 32'h0 : i_wb_mem_rdt;
  end

  assign o_wb_ibus_ack = ack_vec[0];
  assign o_wb_dbus_ack = ack_vec[1];
  assign o_wb_dma_ack  = ack_vec[2];
  assign o_wb_ibus_rdt = rdt_vec[0];
  assign o_wb_dbus_rdt = rdt_vec[1];
  assign o_wb_dma_rdt  = rdt_vec[2];

endmodule

// File: tb/tb_servile_mem_sched.sv
// Bench for servile_mem_sched: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_servile_mem_sched;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r_adr [3];
  logic [31:0] r_dat [3];
  logic [3:0]  r_sel [3];
  logic        r_we  [3];
  logic [2:0]  r_stb;
  logic [31:0] mem_rdt;
  logic        mem_ack;

  logic [31:0] ibus_rdt, dbus_rdt, dma_rdt;
  logic        ibus_ack, dbus_ack, dma_ack;
  logic [31:0] mem_adr, mem_dat;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_stb, err;
  logic [1:0]  owner;

  int tests = 0;
  int fails = 0;

  // model state: current owner (-1 none), cycles already waited, forced quiet cycles, rr start
  int         m_owner = -1;
  int         m_wait  = 0;
  int         m_cool  = 0;
  int         m_rr    = 0;
  logic [2:0] m_ack_prev = '0;

  servile_mem_sched #(.timeout(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_ibus_adr(r_adr[0]), .i_wb_ibus_stb(r_stb[0]),
    .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
    .i_wb_dbus_adr(r_adr[1]), .i_wb_dbus_dat(r_dat[1]), .i_wb_dbus_sel(r_sel[1]),
    .i_wb_dbus_we(r_we[1]), .i_wb_dbus_stb(r_stb[1]),
    .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
    .i_wb_dma_adr(r_adr[2]), .i_wb_dma_dat(r_dat[2]), .i_wb_dma_sel(r_sel[2]),
    .i_wb_dma_we(r_we[2]), .i_wb_dma_stb(r_stb[2]),
    .o_wb_dma_rdt(dma_rdt), .o_wb_dma_ack(dma_ack),
    .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
    .o_wb_mem_we(mem_we), .o_wb_mem_stb(mem_stb),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
    .o_err(err), .o_owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Per-cycle reference: outputs follow from who owns the port and how long it has waited.
  always @(negedge clk) begin
    logic        e_stb, e_err, done, ostb;
    logic [2:0]  e_ack;
    logic [1:0]  e_owner;
    logic [31:0] e_rdt [3];
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we;
    e_stb = 0; e_err = 0; e_ack = '0; e_owner = 2'd3; done = 0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 0;
    for (int r = 0; r < 3; r++) e_rdt[r] = mem_rdt;
    if (rst) begin
      m_owner = -1; m_wait = 0; m_cool = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      if (m_cool > 0) m_cool--;
      else begin
        for (int k = 0; k < 3; k++) begin
          if (m_owner < 0 && r_stb[(m_rr + k) % 3]) begin
            m_owner = (m_rr + k) % 3;
            m_wait  = 0;
          end
        end
      end
    end else begin
      e_owner = 2'(m_owner);
      ostb    = r_stb[m_owner];
      e_adr   = r_adr[m_owner];
      e_dat   = (m_owner == 0) ? 32'h0 : r_dat[m_owner];
      e_sel   = (m_owner == 0) ? 4'hf : r_sel[m_owner];
      e_we    = (m_owner == 0) ? 1'b0 : r_we[m_owner];
      if (!ostb) done = 1;
      else if (mem_ack) begin
        e_stb = 1; e_ack[m_owner] = 1; done = 1;
      end else if (m_wait == TMO) begin
        e_ack[m_owner] = 1; e_err = 1; e_rdt[m_owner] = 32'h0; done = 1;
      end else begin
        e_stb = 1; m_wait++;
      end
      if (done) begin
        m_rr = (m_owner + 1) % 3; m_owner = -1; m_cool = 1;
      end
    end
    m_ack_prev = e_ack;
    chk("mdl_mem_stb", mem_stb, e_stb);
    chk("mdl_owner", owner, e_owner);
    chk("mdl_err", err, e_err);
    chk("mdl_acks", {dma_ack, dbus_ack, ibus_ack}, e_ack);
    chk("mdl_ibus_rdt", ibus_rdt, e_rdt[0]);
    chk("mdl_dbus_rdt", dbus_rdt, e_rdt[1]);
    chk("mdl_dma_rdt", dma_rdt, e_rdt[2]);
    if (e_stb) begin
      chk("mdl_mem_adr", mem_adr, e_adr);
      chk("mdl_mem_dat", mem_dat, e_dat);
      chk("mdl_mem_sel", mem_sel, e_sel);
      chk("mdl_mem_we", mem_we, e_we);
    end
  end

  int exp_own [11] = '{3, 0, 3, 3, 1, 3, 3, 2, 3, 3, 0};

  initial begin
    rst = 1; r_stb = '0; mem_ack = 0; mem_rdt = '0;
    for (int r = 0; r < 3; r++) begin
      r_adr[r] = 32'h1000 * (r + 1); r_dat[r] = 32'h0; r_sel[r] = 4'h0; r_we[r] = 0;
    end
    repeat (3) tick();
    rst = 0;
    sample();
    chk("rst_owner", owner, 2'd3);
    chk("rst_mem_stb", mem_stb, 1'b0);
    chk("rst_acks", {dma_ack, dbus_ack, ibus_ack}, 3'b000);
    chk("rst_err", err, 1'b0);

    // fairness: everyone requests, memory acks immediately
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin r_stb = 3'b111; mem_ack = 1; end
      sample();
      chk("fair_owner", owner, exp_own[i]);
      chk("fair_stb", mem_stb, exp_own[i] != 3);
    end
    tick(); r_stb = '0; mem_ack = 0;
    tick();

    // single ibus fetch
    tick(); r_adr[0] = 32'h100; r_stb[0] = 1; mem_rdt = 32'h13;
    sample(); chk("if_idle_stb", mem_stb, 1'b0);
    tick();
    sample();
    chk("if_stb", mem_stb, 1'b1); chk("if_adr", mem_adr, 32'h100);
    chk("if_we", mem_we, 1'b0); chk("if_sel", mem_sel, 4'hf);
    chk("if_owner", owner, 2'd0); chk("if_noack", ibus_ack, 1'b0);
    tick(); mem_ack = 1;
    sample(); chk("if_ack", ibus_ack, 1'b1); chk("if_rdt", ibus_rdt, 32'h13);
    tick(); mem_ack = 0; r_stb[0] = 0;
    sample(); chk("if_ack_once", ibus_ack, 1'b0); chk("if_owner_gap", owner, 2'd3);
    tick();

    // dbus write beats a simultaneous ibus request (rr points at dbus)
    tick();
    r_adr[1] = 32'h2000; r_dat[1] = 32'hDEADBEEF; r_sel[1] = 4'b0011; r_we[1] = 1;
    r_stb[1] = 1; r_stb[0] = 1;
    tick();
    sample();
    chk("dw_owner", owner, 2'd1); chk("dw_adr", mem_adr, 32'h2000);
    chk("dw_dat", mem_dat, 32'hDEADBEEF); chk("dw_sel", mem_sel, 4'b0011);
    chk("dw_we", mem_we, 1'b1);
    tick(); mem_ack = 1;
    sample(); chk("dw_ack", dbus_ack, 1'b1); chk("dw_ibus_noack", ibus_ack, 1'b0);
    tick(); mem_ack = 0; r_stb = '0;
    tick();

    // dma read times out on the fifth busy cycle
    tick(); r_adr[2] = 32'h3000; r_we[2] = 0; r_stb[2] = 1; mem_rdt = 32'h55AA55AA;
    for (int c = 1; c <= 4; c++) begin
      tick(); sample();
      chk("to_wait_stb", mem_stb, 1'b1); chk("to_wait_err", err, 1'b0);
      chk("to_wait_ack", dma_ack, 1'b0);
    end
    tick(); sample();
    chk("to_ack", dma_ack, 1'b1); chk("to_err", err, 1'b1);
    chk("to_rdt", dma_rdt, 32'h0); chk("to_stb_drop", mem_stb, 1'b0);
    tick(); r_stb[2] = 0;
    tick(); mem_ack = 1;
    sample(); chk("to_stray", {dma_ack, dbus_ack, ibus_ack}, 3'b000);
    tick(); mem_ack = 0;

    // ack lands exactly on the timeout cycle
    tick(); r_adr[1] = 32'h44; r_we[1] = 0; r_stb[1] = 1;
    repeat (4) tick();
    tick(); mem_ack = 1; mem_rdt = 32'hCAFE0001;
    sample();
    chk("race_ack", dbus_ack, 1'b1); chk("race_err", err, 1'b0);
    chk("race_rdt", dbus_rdt, 32'hCAFE0001);
    tick(); mem_ack = 0; r_stb = '0;
    tick();

    // reset in the second busy cycle of a dbus transfer
    tick(); r_stb[1] = 1;
    tick();
    tick(); rst = 1; mem_ack = 1;
    sample(); chk("mr_rst_acks", {dma_ack, dbus_ack, ibus_ack}, 3'b000);
    chk("mr_rst_stb", mem_stb, 1'b0);
    tick(); rst = 0; mem_ack = 0; r_stb[0] = 1;
    sample();
    chk("mr_stb", mem_stb, 1'b0); chk("mr_owner", owner, 2'd3);
    chk("mr_acks", {dma_ack, dbus_ack, ibus_ack}, 3'b000);
    tick(); sample(); chk("mr_rr_ibus", owner, 2'd0);
    tick(); mem_ack = 1;
    tick(); mem_ack = 0; r_stb = '0;
    repeat (2) tick();

    // randomized traffic
    for (int n = 0; n < 5000; n++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < 3; r++) begin
        if (r_stb[r]) begin
          if (m_ack_prev[r] || $urandom_range(0, 39) == 0) r_stb[r] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          r_stb[r] = 1; r_adr[r] = $urandom; r_dat[r] = $urandom;
          r_sel[r] = 4'($urandom); r_we[r] = 1'($urandom);
        end
      end
      mem_rdt = $urandom;
      if (m_owner >= 0 && r_stb[m_owner]) mem_ack = ($urandom_range(0, 3) == 0);
      else mem_ack = (m_owner < 0) && ($urandom_range(0, 9) == 0);
    end
    tick(); rst = 0; r_stb = '0; mem_ack = 0;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
